// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units.
// Holds the controller state encoding and small sizing helpers.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_RUN      = 2'b01,
        S_DONE     = 2'b10,
        S_RESERVED = 2'b11
    } state_t;

    // Step counter width: ceil(log2(width)), but never narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = 1;
        while ((32'(1) << w) < width) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell: sum and carry-out of three input bits.
module full_adder (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic s_out,
    output logic ca_out
);

    assign s_out  = a_in ^ b_in ^ c_in;
    assign ca_out = (a_in & b_in) | (c_in & (a_in ^ b_in));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder evaluated LSB first, one bit per clock,
// with a start/busy/done handshake and registered result outputs.
module serial_add_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             ca_out
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] res_sr_r;
    logic             cy_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             ca_r;

    logic             fa_s_s;
    logic             fa_ca_s;
    logic [WIDTH-1:0] res_next_s;

    full_adder u_fa (
        .a_in   (a_sr_r[0]),
        .b_in   (b_sr_r[0]),
        .c_in   (cy_r),
        .s_out  (fa_s_s),
        .ca_out (fa_ca_s)
    );

    // New sum bit enters at the MSB; the shift form also covers WIDTH == 1.
    assign res_next_s = WIDTH'({fa_s_s, res_sr_r} >> 1);

    // Controller FSM with the datapath shift registers and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_r  <= S_IDLE;
            a_sr_r   <= '0;
            b_sr_r   <= '0;
            res_sr_r <= '0;
            cy_r     <= 1'b0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sum_r    <= '0;
            ca_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start_in) begin
                        a_sr_r  <= a_in;
                        b_sr_r  <= b_in;
                        cy_r    <= c_in;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= S_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    res_sr_r <= res_next_s;
                    cy_r     <= fa_ca_s;
                    a_sr_r   <= a_sr_r >> 1;
                    b_sr_r   <= b_sr_r >> 1;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    busy_r   <= 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        sum_r   <= res_next_s;
                        ca_r    <= fa_ca_s;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= S_RUN;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle.
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_out = busy_r;
    assign done_out = done_r;
    assign sum_out  = sum_r;
    assign ca_out   = ca_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8) with a result
// scoreboard filled at accept and drained at the done pulse.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         ca;

    int           checks = 0;
    int           errors = 0;
    logic [W:0]   sb_q[$];
    logic [W-1:0] hold_sum;
    logic         hold_ca;
    logic [W:0]   exp_v;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .start_in (start),
        .a_in     (a),
        .b_in     (b),
        .c_in     (c),
        .busy_out (busy),
        .done_out (done),
        .sum_out  (sum),
        .ca_out   (ca)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic eb, input logic ed,
                            input logic [W-1:0] es, input logic ec);
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".sum"},  32'(sum),  32'(es));
        chk({tag, ".ca"},   32'(ca),   32'(ec));
    endtask

    task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec);
        sb_q.push_back({1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec});
    endtask

    // One operation from accept to return to idle, with optional mid-run
    // start request or mid-run reset.
    task automatic run_op(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                          input logic ec, input bit mid_start, input bit abort);
        a = ea; b = eb; c = ec; start = 1'b1;
        push_exp(ea, eb, ec);
        step();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); c = 1'($urandom);
        chk_outs({tag, ".e0"}, 1'b1, 1'b0, hold_sum, hold_ca);
        for (int i = 1; i <= W + 1; i++) begin
            if (mid_start && i == 3) begin
                start = 1'b1; a = 8'hAA; b = 8'h55; c = 1'b0;
            end
            if (abort && i == 4) begin
                rst_n = 1'b0;
                step();
                void'(sb_q.pop_back());
                hold_sum = '0;
                hold_ca  = 1'b0;
                chk_outs({tag, ".rst"}, 1'b0, 1'b0, 8'h00, 1'b0);
                rst_n = 1'b1;
                step();
                chk_outs({tag, ".post_rst"}, 1'b0, 1'b0, 8'h00, 1'b0);
                return;
            end
            step();
            start = 1'b0;
            if (i < W) begin
                chk_outs({tag, ".run"}, 1'b1, 1'b0, hold_sum, hold_ca);
            end else if (i == W) begin
                exp_v    = sb_q.pop_front();
                hold_sum = exp_v[W-1:0];
                hold_ca  = exp_v[W];
                chk_outs({tag, ".done"}, 1'b1, 1'b1, hold_sum, hold_ca);
            end else begin
                chk_outs({tag, ".idle"}, 1'b0, 1'b0, hold_sum, hold_ca);
            end
        end
    endtask

    initial begin
        hold_sum = '0;
        hold_ca  = 1'b0;
        rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; c = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_outs("reset", 1'b0, 1'b0, 8'h00, 1'b0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        step();
        chk_outs("idle", 1'b0, 1'b0, 8'h00, 1'b0);

        run_op("op_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("val_0f_01", 32'(sum), 32'h10);
        run_op("op_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("val_ff_01", 32'({ca, sum}), 32'h100);
        run_op("op_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("val_ff_ff_c", 32'({ca, sum}), 32'h1FF);
        run_op("op_00_00_c", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("val_00_00_c", 32'({ca, sum}), 32'h001);

        run_op("op_mid_start", 8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
        chk("val_mid_start", 32'(sum), 32'h46);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_outs("dropped_req", 1'b0, 1'b0, 8'h46, 1'b0);
        end

        run_op("op_abort", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < W + 2; i++) begin
            chk("abort_no_done", 32'(done), 32'h0);
            step();
        end
        run_op("op_05_03", 8'h05, 8'h03, 1'b0, 1'b0, 1'b0);
        chk("val_05_03", 32'(sum), 32'h08);

        a = 8'h80; b = 8'h80; c = 1'b0; start = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if (n % 10 == 0) push_exp(a, b, c);
            step();
            if (n % 10 == 8) begin
                exp_v    = sb_q.pop_front();
                hold_sum = exp_v[W-1:0];
                hold_ca  = exp_v[W];
                chk_outs("held.done", 1'b1, 1'b1, hold_sum, hold_ca);
            end else begin
                chk_outs("held.gap", (n % 10 != 9) ? 1'b1 : 1'b0, 1'b0, hold_sum, hold_ca);
            end
        end
        chk("held_val", 32'({ca, sum}), 32'h100);
        start = 1'b0;
        step();
        chk_outs("final_idle", 1'b0, 1'b0, 8'h00, 1'b1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
